// File: rtl/sysref_gen.sv
// sysref_gen: PL-side SYSREF pulse generator for multi-tile sync.
// Produces burst-counted or continuous SYSREF pulses on FPGAPL_ref_clk.
// Software starts it with a start/stop handshake and gets done and pulses_sent back.
// Optional feature: define SYSREF_GEN_ALIGN_EN to align the first pulse to a
// free-running LMFC-rate counter. Without it, the first pulse follows accept at once.
module sysref_gen #(
    parameter int PERIOD      = 64,
    parameter int HIGH_CYCLES = 32,
    parameter int CNT_W       = 8
) (
    input  logic             FPGAPL_ref_clk,
    input  logic             FPGAPL_rst_n,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic             done,
    output logic             sysref_out,
    output logic             sysref_rise,
    output logic [CNT_W-1:0] pulses_sent
);

    localparam int               PH_W    = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(PERIOD - 1);
    localparam logic [PH_W-1:0]  PH_HIGH = PH_W'(HIGH_CYCLES);
    localparam logic [PH_W-1:0]  PH_ONE  = PH_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic             is_burst_q, is_burst_d;
    logic [CNT_W-1:0] burst_len_q, burst_len_d;
    logic             stop_flag_q, stop_flag_d;
    logic [CNT_W-1:0] count_base, count_d;
    logic             accept;
    logic             zero_burst;
    logic             aligned_now;
    logic             busy_d, done_d, sysref_d, rise_d;

`ifdef SYSREF_GEN_ALIGN_EN
    logic [PH_W-1:0] lmfc_cnt;

    // Free-running LMFC-rate counter. Entering RUN when it wraps makes pulse phase equal lmfc_cnt.
    always_ff @(posedge FPGAPL_ref_clk) begin
        if (!FPGAPL_rst_n) lmfc_cnt <= '0;
        else               lmfc_cnt <= (lmfc_cnt == PH_LAST) ? '0 : lmfc_cnt + PH_ONE;
    end

    assign aligned_now = (lmfc_cnt == PH_LAST);
`else
    assign aligned_now = 1'b1;
`endif

    assign accept     = (state_q == IDLE) && start && !stop && (mode == 2'b01 || mode == 2'b10);
    assign zero_burst = (mode == 2'b01) && (burst_len == '0);

    // Next-state, phase and latched-request logic.
    // NOTE: every variable gets a default first, so no path through the case infers a latch.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        is_burst_d  = is_burst_q;
        burst_len_d = burst_len_q;
        stop_flag_d = stop_flag_q;
        case (state_q)
            IDLE: begin
                phase_d = '0;
                if (accept) begin
                    is_burst_d  = (mode == 2'b01);
                    burst_len_d = burst_len;
                    stop_flag_d = 1'b0;
                    // An empty burst spends one busy cycle in ARM before completing.
                    if (zero_burst)       state_d = ARM;
                    else if (aligned_now) state_d = RUN;
                    else                  state_d = ARM;
                end
            end
            ARM: begin
                phase_d = '0;
                if (stop || (is_burst_q && burst_len_q == '0)) state_d = DRAIN;
                else if (aligned_now)                          state_d = RUN;
            end
            RUN: begin
                if (stop) stop_flag_d = 1'b1;
                if (phase_q == PH_LAST) begin
                    // Only a period boundary may end the run, so pulses are never truncated.
                    phase_d = '0;
                    if (stop_flag_q || stop || (is_burst_q && pulses_sent == burst_len_q))
                        state_d = DRAIN;
                end else begin
                    phase_d = phase_q + PH_ONE;
                end
            end
            DRAIN: begin
                state_d     = IDLE;
                stop_flag_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output values for the coming cycle, derived from the next state so outputs can be flops.
    always_comb begin
        rise_d     = (state_d == RUN) && (phase_d == '0);
        sysref_d   = (state_d == RUN) && (phase_d < PH_HIGH);
        busy_d     = (state_d == ARM) || (state_d == RUN);
        done_d     = (state_d == DRAIN);
        count_base = accept ? '0 : pulses_sent;
        count_d    = count_base;
        if (rise_d && count_base != CNT_MAX) count_d = count_base + CNT_ONE;
    end

    // State and output registers with synchronous active-low reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge FPGAPL_ref_clk) begin
        if (!FPGAPL_rst_n) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            is_burst_q  <= 1'b0;
            burst_len_q <= '0;
            stop_flag_q <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sysref_out  <= 1'b0;
            sysref_rise <= 1'b0;
            pulses_sent <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            is_burst_q  <= is_burst_d;
            burst_len_q <= burst_len_d;
            stop_flag_q <= stop_flag_d;
            busy        <= busy_d;
            done        <= done_d;
            sysref_out  <= sysref_d;
            sysref_rise <= rise_d;
            pulses_sent <= count_d;
        end
    end

endmodule
